ram_16x8_programavel: RTL and testbench
=======================================

# ram_16x8_programavel

16-word × 8-bit program/data RAM that answers the 4-bit address driven by the MAR. In program mode, the operator writes a byte from the DIP switches into the addressed word using a debounced push-button, one write per press. In run mode, the RAM drives the addressed word onto the W-bus whenever the controller asserts RAM_OUT. The block sits between the MAR address output, the front-panel switches/button and the 8-bit W-bus.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive stable samples required for press or release; legal range 1..255.
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  reset, synchronous, active-high.
- programm_run  in  1  1 = run mode (bus reads allowed), 0 = program mode (button writes allowed).
- addr  in  4  word address from the MAR.
- RAM_OUT  in  1  controller request to drive the bus with mem[addr].
- ram_dip  in  8  data switches used as write data.
- write_btn  in  1  raw, asynchronous, bouncing write push-button; active-high.
- bus_out  out  8  mem[addr] when bus_oe=1, otherwise 8'h00.
- bus_oe  out  1  W-bus drive enable.
- data_view  out  8  mem[addr] unconditionally (front-panel LEDs).
- write_busy  out  1  high whenever the FSM is not in IDLE.
- write_done  out  1  one-cycle pulse during the committing WRITE cycle.

## Operation
- Storage: 16×8 array. clear does NOT initialise the array. Contents are undefined until written, and clear never alters them.
- Read path (combinational):
  - data_view = mem[addr].
  - bus_oe = RAM_OUT & programm_run & ~clear.
  - bus_out = bus_oe ? mem[addr] : 8'h00.
- Button synchroniser: two flip-flops, write_btn → btn_s. Both reset to 0.
- Debounce counter: width ceil(log2(DEBOUNCE_CYCLES+1)). Cleared on every state change.
- FSM states (reset state IDLE):
  - IDLE: if programm_run=0 and btn_s=1, go to PRESS.
  - PRESS: if btn_s=1, increment the counter; once DEBOUNCE_CYCLES consecutive high samples have been taken in PRESS, go to WRITE. If btn_s=0, return to IDLE with no write.
  - WRITE: single cycle. If programm_run=0, set mem[addr] ← ram_dip at the end of the cycle and assert write_done. Always go to RELEASE.
  - RELEASE: wait for DEBOUNCE_CYCLES consecutive btn_s=0 samples, then go to IDLE. A btn_s=1 sample restarts the count.
- Abort: programm_run=1 in PRESS or RELEASE forces IDLE on the next edge. In WRITE, programm_run=1 suppresses the write and write_done.
- Holding the button down produces exactly one write. A bounce shorter than DEBOUNCE_CYCLES produces no write.
- addr and ram_dip are sampled in the WRITE cycle only. Changing them earlier has no effect.

## Timing
- Reset values after a clear edge: state IDLE, synchroniser 0, counter 0, write_busy=0, write_done=0, bus_oe=0, bus_out=8'h00.
- clear asserted mid-operation (any state): IDLE on the next edge, no write, and no write_done in that cycle.
- Press latency, with E0 = first edge that samples write_btn=1 and the button held stable:
  - btn_s=1 after E1.
  - PRESS entered at E2.
  - WRITE entered at E(2+DEBOUNCE_CYCLES).
  - Array updated at E(3+DEBOUNCE_CYCLES); readable on data_view immediately after that edge.
  - With the default of 4: WRITE after E6, write_done high E6–E7, data visible after E7.
- write_busy rises after E2 and falls after the edge that returns the FSM to IDLE.
- Release: RELEASE → IDLE DEBOUNCE_CYCLES edges after btn_s first samples 0, i.e. DEBOUNCE_CYCLES+2 edges after write_btn falls.
- Read: zero-cycle combinational path from addr, RAM_OUT and programm_run to bus_out/bus_oe. A write becomes visible on the read path the cycle after the committing edge.

## Test plan
- Basic write/read (DEBOUNCE_CYCLES=4):
  - programm_run=0, addr=4'h3, ram_dip=8'hA5, hold write_btn for 12 cycles.
  - Required: write_done pulses exactly once, high E6–E7; data_view=8'hA5 after E7.
  - Then programm_run=1, RAM_OUT=1 → bus_oe=1, bus_out=8'hA5.
- Bounce rejection: pulse write_btn high for 3 cycles, low for 2, high for 3, then low, at addr=4'h3 with ram_dip=8'h00 → no write_done, mem[3] stays 8'hA5, write_busy returns to 0.
- Held button: hold write_btn for 50 cycles at addr=4'h7, ram_dip=8'h11, changing ram_dip to 8'h22 at cycle 30 → exactly one write, mem[7]=8'h11.
- Mode gating:
  - programm_run=1, full button press → no write and write_busy stays 0.
  - programm_run=0 with RAM_OUT=1 → bus_oe=0, bus_out=8'h00.
- Abort paths:
  - Raise programm_run during PRESS → IDLE next cycle, no write.
  - Assert clear for one cycle while in WRITE → no write_done, mem unchanged, all outputs at reset values.
- Address sweep: write 8'hF0+i to addr i for i=0..15, then read every address in run mode → bus_out=8'hF0+i; clear does not alter any word.

Source files
------------

// File: rtl/ram_16x8_programavel.sv
// ram_16x8_programavel
// 16 x 8 program/data RAM addressed by the MAR.
// Program mode: a debounced front-panel push-button writes the DIP switch
// byte into the addressed word, exactly once per press.
// Run mode: the addressed word is driven onto the W-bus on RAM_OUT.
// The storage array has no reset; clear only affects the button/FSM logic.
module ram_16x8_programavel #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       programm_run,
  input  logic [3:0] addr,
  input  logic       RAM_OUT,
  input  logic [7:0] ram_dip,
  input  logic       write_btn,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic [7:0] data_view,
  output logic       write_busy,
  output logic       write_done
);

  // Counter must hold 0..DEBOUNCE_CYCLES-1; terminal value ends a debounce window.
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync1;
  logic             r_btn_s;
  logic [7:0]       r_mem [16];

  logic             w_commit;
  logic [7:0]       w_rd_data;

  // A write commits only from WRITE in program mode and never while clear is high.
  assign w_commit   = (r_state == ST_WRITE) & ~programm_run & ~clear;
  assign w_rd_data  = r_mem[addr];

  assign data_view  = w_rd_data;
  assign bus_oe     = RAM_OUT & programm_run & ~clear;
  assign bus_out    = bus_oe ? w_rd_data : 8'h00;
  assign write_busy = (r_state != ST_IDLE);
  assign write_done = w_commit;

  // Two-stage synchroniser bringing the raw button into the clock domain.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_sync1 <= write_btn;
      r_btn_s <= r_sync1;
    end
  end

  // Press/write/release sequencer with a shared debounce counter.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!programm_run && r_btn_s) begin
            r_state <= ST_PRESS;
            r_cnt   <= CNT_ZERO;
          end else begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
          end
        end
        ST_PRESS: begin
          if (programm_run || !r_btn_s) begin
            // Mode change or a bounce: give up without writing.
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_WRITE;
            r_cnt   <= CNT_ZERO;
          end else begin
            r_state <= ST_PRESS;
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        ST_WRITE: begin
          // Single cycle; always wait for release so a held button writes once.
          r_state <= ST_RELEASE;
          r_cnt   <= CNT_ZERO;
        end
        ST_RELEASE: begin
          if (programm_run) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
          end else if (r_btn_s) begin
            // Any high sample restarts the release window.
            r_state <= ST_RELEASE;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
          end else begin
            r_state <= ST_RELEASE;
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Storage array: no reset, written only by a committing WRITE cycle.
  always_ff @(posedge clock) begin
    if (w_commit) begin
      r_mem[addr] <= ram_dip;
    end
  end

endmodule

// File: tb/tb_ram_16x8_programavel.sv
// Self-checking bench for ram_16x8_programavel (DEBOUNCE_CYCLES = 4).
// Expected contents come from a simple array model updated by the rule
// "a clean program-mode press held at least D+1 cycles writes once".
module tb_ram_16x8_programavel;

  localparam int D = 4;

  logic       clock;
  logic       clear;
  logic       programm_run;
  logic [3:0] addr;
  logic       RAM_OUT;
  logic [7:0] ram_dip;
  logic       write_btn;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] data_view;
  logic       write_busy;
  logic       write_done;

  int n_checks;
  int n_fail;

  logic [7:0] exp_mem [16];

  ram_16x8_programavel #(.DEBOUNCE_CYCLES(D)) dut (
    .clock        (clock),
    .clear        (clear),
    .programm_run (programm_run),
    .addr         (addr),
    .RAM_OUT      (RAM_OUT),
    .ram_dip      (ram_dip),
    .write_btn    (write_btn),
    .bus_out      (bus_out),
    .bus_oe       (bus_oe),
    .data_view    (data_view),
    .write_busy   (write_busy),
    .write_done   (write_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Release the button and wait (bounded) for the FSM to return to IDLE.
  task automatic wait_idle(inout int dones, output bit timeout);
    bit seen_idle;
    seen_idle = 1'b0;
    write_btn = 1'b0;
    for (int k = 0; k < 200 && !seen_idle; k++) begin
      cycle();
      if (write_done === 1'b1) dones++;
      if (k >= 3 && write_busy === 1'b0) seen_idle = 1'b1;
    end
    timeout = !seen_idle;
    cycle();
  endtask

  // Clean program-mode press held for 'hold' cycles; counts write_done pulses.
  task automatic do_press(input logic [3:0] a, input logic [7:0] d, input int hold,
                          output int dones, output bit timeout);
    dones = 0;
    programm_run = 1'b0;
    RAM_OUT = 1'b0;
    addr = a;
    ram_dip = d;
    write_btn = 1'b1;
    for (int k = 0; k < hold; k++) begin
      cycle();
      if (write_done === 1'b1) dones++;
    end
    wait_idle(dones, timeout);
  endtask

  task automatic test_reset();
    clear = 1'b1; programm_run = 1'b1; RAM_OUT = 1'b1; write_btn = 1'b0;
    addr = 4'h0; ram_dip = 8'h00;
    cycle(); cycle();
    n_checks++;
    if (write_busy !== 1'b0 || write_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b done=%b required busy=0 done=0", write_busy, write_done);
    end
    n_checks++;
    if (bus_oe !== 1'b0 || bus_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_bus: oe=%b out=%h required oe=0 out=00", bus_oe, bus_out);
    end
    clear = 1'b0; programm_run = 1'b0; RAM_OUT = 1'b0;
    cycle();
  endtask

  task automatic test_basic_write();
    int dones;
    int done_k;
    bit busy_early;
    bit busy_e2;
    bit to;
    dones = 0; done_k = -1; busy_early = 1'b0; busy_e2 = 1'b0;
    programm_run = 1'b0; addr = 4'h3; ram_dip = 8'hA5; write_btn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (write_done === 1'b1) begin dones++; done_k = k; end
      if (k < 2 && write_busy === 1'b1) busy_early = 1'b1;
      if (k == 2) busy_e2 = write_busy;
      if (k == D + 3) begin
        n_checks++;
        if (data_view !== 8'hA5) begin
          n_fail++;
          $display("FAIL basic_view_after_commit: got %h required a5", data_view);
        end
      end
    end
    n_checks++;
    if (dones != 1 || done_k != D + 2) begin
      n_fail++;
      $display("FAIL basic_done_pulse: count=%0d at_edge=%0d required count=1 at_edge=%0d", dones, done_k, D + 2);
    end
    n_checks++;
    if (busy_early || busy_e2 !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_rise: early=%b after_e2=%b required early=0 after_e2=1", busy_early, busy_e2);
    end
    wait_idle(dones, to);
    exp_mem[3] = 8'hA5;
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL basic_release_timeout: busy stuck=%b required 0", write_busy);
    end
    programm_run = 1'b1; RAM_OUT = 1'b1; #1;
    n_checks++;
    if (bus_oe !== 1'b1 || bus_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_bus_read: oe=%b out=%h required oe=1 out=a5", bus_oe, bus_out);
    end
    programm_run = 1'b0; RAM_OUT = 1'b0;
    cycle();
  endtask

  task automatic test_bounce();
    logic lvl [9];
    int dones;
    bit to;
    lvl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    dones = 0;
    programm_run = 1'b0; addr = 4'h3; ram_dip = 8'h00;
    for (int k = 0; k < 9; k++) begin
      write_btn = lvl[k];
      cycle();
      if (write_done === 1'b1) dones++;
    end
    wait_idle(dones, to);
    n_checks++;
    if (dones != 0 || data_view !== exp_mem[3] || to || write_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_reject: dones=%0d mem3=%h busy=%b required dones=0 mem3=%h busy=0",
               dones, data_view, write_busy, exp_mem[3]);
    end
  endtask

  task automatic test_held_button();
    int dones;
    bit to;
    dones = 0;
    programm_run = 1'b0; addr = 4'h7; ram_dip = 8'h11; write_btn = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (k == 30) ram_dip = 8'h22;
      cycle();
      if (write_done === 1'b1) dones++;
    end
    wait_idle(dones, to);
    exp_mem[7] = 8'h11;
    n_checks++;
    if (dones != 1 || data_view !== exp_mem[7] || to) begin
      n_fail++;
      $display("FAIL held_single_write: dones=%0d mem7=%h required dones=1 mem7=%h", dones, data_view, exp_mem[7]);
    end
  endtask

  task automatic test_mode_gating();
    int dones;
    bit busy_seen;
    dones = 0; busy_seen = 1'b0;
    programm_run = 1'b1; RAM_OUT = 1'b0; addr = 4'h7; ram_dip = 8'h99; write_btn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (write_done === 1'b1) dones++;
      if (write_busy !== 1'b0) busy_seen = 1'b1;
    end
    write_btn = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (write_busy !== 1'b0) busy_seen = 1'b1;
    end
    n_checks++;
    if (dones != 0 || busy_seen || data_view !== exp_mem[7]) begin
      n_fail++;
      $display("FAIL gating_run_press: dones=%0d busy_seen=%b mem7=%h required 0 0 %h",
               dones, busy_seen, data_view, exp_mem[7]);
    end
    programm_run = 1'b0; RAM_OUT = 1'b1; #1;
    n_checks++;
    if (bus_oe !== 1'b0 || bus_out !== 8'h00) begin
      n_fail++;
      $display("FAIL gating_prog_bus: oe=%b out=%h required oe=0 out=00", bus_oe, bus_out);
    end
    RAM_OUT = 1'b0;
    cycle();
  endtask

  task automatic test_abort_press();
    int dones;
    dones = 0;
    programm_run = 1'b0; addr = 4'h3; ram_dip = 8'h5A; write_btn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (write_done === 1'b1) dones++;
    end
    n_checks++;
    if (write_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_in_press: busy=%b required 1", write_busy);
    end
    programm_run = 1'b1; write_btn = 1'b0;
    cycle();
    n_checks++;
    if (write_busy !== 1'b0 || write_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_to_idle: busy=%b done=%b required 0 0", write_busy, write_done);
    end
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (write_done === 1'b1) dones++;
    end
    programm_run = 1'b0;
    cycle(); cycle();
    n_checks++;
    if (dones != 0 || data_view !== exp_mem[3]) begin
      n_fail++;
      $display("FAIL abort_no_write: dones=%0d mem3=%h required 0 %h", dones, data_view, exp_mem[3]);
    end
  endtask

  task automatic test_abort_clear();
    programm_run = 1'b0; RAM_OUT = 1'b0; addr = 4'h3; ram_dip = 8'h3C; write_btn = 1'b1;
    for (int k = 0; k <= D + 2; k++) cycle();
    n_checks++;
    if (write_done !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_reach_write: done=%b required 1", write_done);
    end
    clear = 1'b1; write_btn = 1'b0; #1;
    n_checks++;
    if (write_done !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_masks_done: done=%b required 0", write_done);
    end
    cycle();
    programm_run = 1'b1; RAM_OUT = 1'b1; #1;
    n_checks++;
    if (write_busy !== 1'b0 || write_done !== 1'b0 || bus_oe !== 1'b0 || bus_out !== 8'h00) begin
      n_fail++;
      $display("FAIL clear_outputs: busy=%b done=%b oe=%b out=%h required 0 0 0 00",
               write_busy, write_done, bus_oe, bus_out);
    end
    clear = 1'b0; #1;
    n_checks++;
    if (bus_oe !== 1'b1 || bus_out !== exp_mem[3]) begin
      n_fail++;
      $display("FAIL clear_mem_kept: oe=%b out=%h required 1 %h", bus_oe, bus_out, exp_mem[3]);
    end
    programm_run = 1'b0; RAM_OUT = 1'b0;
    for (int k = 0; k < D + 4; k++) cycle();
  endtask

  task automatic test_address_sweep();
    int dones;
    bit to;
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      do_press(4'(i), 8'hF0 + 8'(i), D + 4, dones, to);
      exp_mem[i] = 8'hF0 + 8'(i);
      if (dones != 1 || to) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL sweep_writes: bad_presses=%0d required 0", bad);
    end
    programm_run = 1'b1; RAM_OUT = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        addr = 4'(i); #1;
        n_checks++;
        if (bus_oe !== 1'b1 || bus_out !== exp_mem[i] || data_view !== exp_mem[i]) begin
          n_fail++;
          $display("FAIL sweep_read pass=%0d addr=%0d: oe=%b out=%h view=%h required 1 %h",
                   pass, i, bus_oe, bus_out, data_view, exp_mem[i]);
        end
      end
      clear = 1'b1;
      cycle(); cycle();
      clear = 1'b0;
      cycle();
    end
    programm_run = 1'b0; RAM_OUT = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [7:0] d;
    logic [3:0] ra;
    logic       ro;
    int hold;
    int dones;
    int exp_dones;
    bit to;
    for (int it = 0; it < 24; it++) begin
      a = 4'($urandom_range(15));
      d = 8'($urandom_range(255));
      hold = $urandom_range(D + 6, 1);
      exp_dones = (hold >= D + 1) ? 1 : 0;
      do_press(a, d, hold, dones, to);
      if (exp_dones == 1) exp_mem[a] = d;
      n_checks++;
      if (dones != exp_dones || to) begin
        n_fail++;
        $display("FAIL random_press it=%0d hold=%0d: dones=%0d timeout=%b required %0d 0",
                 it, hold, dones, to, exp_dones);
      end
      ra = 4'($urandom_range(15));
      ro = 1'($urandom_range(1));
      programm_run = 1'b1; RAM_OUT = ro; addr = ra; #1;
      n_checks++;
      if (bus_oe !== ro || bus_out !== (ro ? exp_mem[ra] : 8'h00) || data_view !== exp_mem[ra]) begin
        n_fail++;
        $display("FAIL random_read it=%0d addr=%0d: oe=%b out=%h view=%h required %b %h %h",
                 it, ra, bus_oe, bus_out, data_view, ro, (ro ? exp_mem[ra] : 8'h00), exp_mem[ra]);
      end
      programm_run = 1'b0; RAM_OUT = 1'b0;
      cycle();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    test_reset();
    test_basic_write();
    test_bounce();
    test_held_button();
    test_mode_gating();
    test_abort_press();
    test_abort_clear();
    test_address_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
